// File: rtl/cache_wb_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with its own miss
// handler: line write-back and refill bursts over a single-word memory
// port, byte-enable stores, whole-cache flush and saturating hit/miss counters.
module cache_wb_ctrl #(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IDX   = $clog2(LINES);
  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int OFF_W = (OFF == 0) ? 1 : OFF;
  localparam int TAG_W = ADDR_W - 2 - OFF - IDX;
  localparam int DA_W  = IDX + OFF;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WB      = 3'd1;
  localparam logic [2:0] S_REFILL  = 3'd2;
  localparam logic [2:0] S_RESPOND = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;

  logic [2:0]       r_state;
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAG_W-1:0] r_tag_arr [LINES];
  logic [31:0]      r_data    [LINES*WORDS_PER_LINE];

  // Latched miss request; r_idx doubles as the line pointer during a flush
  logic [IDX-1:0]   r_idx;
  logic [TAG_W-1:0] r_tag;
  logic [OFF_W-1:0] r_off;
  logic [OFF_W-1:0] r_beat;
  logic             r_we;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;

  logic             r_resp_valid;
  logic [31:0]      r_resp_rdata;
  logic             r_flush_done;
  logic [31:0]      r_hits;
  logic [31:0]      r_misses;

  logic [IDX-1:0]   w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [OFF_W-1:0] w_off;
  logic             w_hit;
  logic             w_acc;
  logic             w_last_beat;
  logic             w_fl_dirty;
  logic             w_fl_adv;
  logic             w_mem_req;
  logic             w_mem_we;
  logic [TAG_W-1:0] w_line_tag;
  logic [31:0]      w_req_word;
  logic [31:0]      w_lat_word;
  logic             w_dwe;
  logic [DA_W-1:0]  w_dwaddr;
  logic [31:0]      w_dwdata;
  logic             w_tag_we;

  // Flat data-array address; the dummy offset bit is shifted out when a line holds one word
  function automatic logic [DA_W-1:0] f_daddr(input logic [IDX-1:0] idx, input logic [OFF_W-1:0] off);
    return DA_W'({idx, off} >> (OFF_W - OFF));
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    return res;
  endfunction

  assign w_idx       = IDX'(req_addr >> (2 + OFF));
  assign w_tag       = TAG_W'(req_addr >> (2 + OFF + IDX));
  assign w_off       = (OFF == 0) ? '0 : OFF_W'(req_addr >> 2);
  assign w_hit       = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
  assign req_ready   = rst_n && (r_state == S_IDLE) && !flush_req;
  assign w_acc       = req_valid && req_ready;
  assign w_last_beat = (r_beat == OFF_W'(WORDS_PER_LINE - 1));
  assign w_fl_dirty  = r_valid[r_idx] && r_dirty[r_idx];
  assign w_fl_adv    = !w_fl_dirty || (mem_ack && w_last_beat);
  assign w_mem_req   = (r_state == S_WB) || (r_state == S_REFILL) || ((r_state == S_FLUSH) && w_fl_dirty);
  assign w_mem_we    = (r_state == S_WB) || (r_state == S_FLUSH);
  assign w_line_tag  = (r_state == S_REFILL) ? r_tag : r_tag_arr[r_idx];
  assign w_req_word  = r_data[f_daddr(w_idx, w_off)];
  assign w_lat_word  = r_data[f_daddr(r_idx, r_off)];
  assign w_tag_we    = (r_state == S_REFILL) && mem_ack && w_last_beat;

  assign mem_req    = w_mem_req;
  assign mem_we     = w_mem_req && w_mem_we;
  assign mem_addr   = w_mem_req ? ((ADDR_W'({w_line_tag, r_idx}) << (2 + OFF)) | (ADDR_W'(r_beat) << 2)) : '0;
  assign mem_wdata  = (w_mem_req && w_mem_we) ? r_data[f_daddr(r_idx, r_beat)] : '0;
  assign resp_valid = r_resp_valid || (r_state == S_RESPOND);
  assign resp_rdata = (r_state == S_RESPOND) ? w_lat_word : r_resp_rdata;
  assign flush_done = r_flush_done;
  assign hit_count  = r_hits;
  assign miss_count = r_misses;

  // Single data-array write port: store hit, refill beat, or deferred store after refill
  always_comb begin
    w_dwe    = 1'b0;
    w_dwaddr = f_daddr(r_idx, r_beat);
    w_dwdata = mem_rdata;
    if (w_acc && w_hit && req_we) begin
      w_dwe    = 1'b1;
      w_dwaddr = f_daddr(w_idx, w_off);
      w_dwdata = f_merge(w_req_word, req_wdata, req_be);
    end else if ((r_state == S_REFILL) && mem_ack) begin
      w_dwe    = 1'b1;
    end else if ((r_state == S_RESPOND) && r_we) begin
      w_dwe    = 1'b1;
      w_dwaddr = f_daddr(r_idx, r_off);
      w_dwdata = f_merge(w_lat_word, r_wdata, r_be);
    end
  end

  // Data and tag storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (w_dwe)    r_data[w_dwaddr]   <= w_dwdata;
    if (w_tag_we) r_tag_arr[r_idx]   <= r_tag;
  end

  // Miss/flush FSM, line state bits, response and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_idx        <= '0;
      r_tag        <= '0;
      r_off        <= '0;
      r_beat       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_flush_done <= 1'b0;
      r_hits       <= '0;
      r_misses     <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_flush_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush_req) begin
            r_state <= S_FLUSH;
            r_idx   <= '0;
            r_beat  <= '0;
          end else if (w_acc) begin
            if (w_hit) begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= req_we ? w_dwdata : w_req_word;
              if (req_we) r_dirty[w_idx] <= 1'b1;
              if (r_hits != '1) r_hits <= r_hits + 32'd1;
            end else begin
              r_idx   <= w_idx;
              r_tag   <= w_tag;
              r_off   <= w_off;
              r_we    <= req_we;
              r_wdata <= req_wdata;
              r_be    <= req_be;
              r_beat  <= '0;
              if (r_misses != '1) r_misses <= r_misses + 32'd1;
              r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_REFILL;
            end
          end
        end
        S_WB: begin
          if (mem_ack) begin
            if (w_last_beat) begin
              r_dirty[r_idx] <= 1'b0;
              r_beat         <= '0;
              r_state        <= S_REFILL;
            end else begin
              r_beat <= r_beat + OFF_W'(1);
            end
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            if (w_last_beat) begin
              r_valid[r_idx] <= 1'b1;
              r_dirty[r_idx] <= 1'b0;
              r_beat         <= '0;
              r_state        <= S_RESPOND;
            end else begin
              r_beat <= r_beat + OFF_W'(1);
            end
          end
        end
        S_RESPOND: begin
          if (r_we) r_dirty[r_idx] <= 1'b1;
          r_state <= S_IDLE;
        end
        S_FLUSH: begin
          // Clean or invalid lines take one cycle; dirty ones burst out first
          if (w_fl_adv) begin
            r_valid[r_idx] <= 1'b0;
            r_dirty[r_idx] <= 1'b0;
            r_beat         <= '0;
            if (r_idx == IDX'(LINES - 1)) begin
              r_state      <= S_IDLE;
              r_flush_done <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX'(1);
            end
          end else if (mem_ack) begin
            r_beat <= r_beat + OFF_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// Randomized bench for cache_wb_ctrl: a golden CPU-visible memory plus
// per-line residency bookkeeping predicts hits, misses, burst traffic and data.
module tb_cache_wb_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } tr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        flush_req, flush_done;
  logic [31:0] hit_count, miss_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] gold [int unsigned];
  logic [31:0] bmem [int unsigned];
  bit          m_valid [64];
  bit          m_dirty [64];
  int unsigned m_tag   [64];
  int unsigned m_hits, m_misses;
  tr_t         log_q[$];
  tr_t         exp_q[$];
  bit          mem_stall = 1'b0;

  always #5 clk = ~clk;

  cache_wb_ctrl #(.LINES(64), .WORDS_PER_LINE(4), .ADDR_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .flush_req(flush_req), .flush_done(flush_done),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] line_addr(input int unsigned tag, input int unsigned idx, input int unsigned b);
    return 32'((tag << 10) | (idx << 4) | (b << 2));
  endfunction

  // Memory responder: random wait states, stray acks while idle, logs every real beat
  initial begin
    int unsigned wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_stall) continue;
      if (mem_req) begin
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            bmem[mem_addr] = mem_wdata;
            log_q.push_back('{we: 1'b1, addr: mem_addr, data: mem_wdata});
          end else begin
            mem_rdata = bmem_rd(mem_addr);
            log_q.push_back('{we: 1'b0, addr: mem_addr, data: mem_rdata});
          end
          wait_cnt = $urandom % 3;
        end else begin
          wait_cnt--;
        end
      end else begin
        mem_ack   = (($urandom % 8) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  task automatic cmp_traffic(input string tag);
    int unsigned n;
    chk({tag, "_beats"}, 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++) begin
      chk({tag, "_we"},   32'(log_q[i].we), 32'(exp_q[i].we));
      chk({tag, "_addr"}, log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) chk({tag, "_wdata"}, log_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] wa, exp_rd, nv;
    int unsigned idx, tag, n;
    bit hit;
    wa  = addr & ~32'h3;
    idx = (wa >> 4) & 63;
    tag = wa >> 10;
    exp_q.delete();
    log_q.delete();
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx])
        for (int unsigned b = 0; b < 4; b++)
          exp_q.push_back('{we: 1'b1, addr: line_addr(m_tag[idx], idx, b), data: gold_rd(line_addr(m_tag[idx], idx, b))});
      for (int unsigned b = 0; b < 4; b++)
        exp_q.push_back('{we: 1'b0, addr: line_addr(tag, idx, b), data: 32'h0});
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      m_misses++;
    end else begin
      m_hits++;
    end
    exp_rd = gold_rd(wa);
    if (we) begin
      nv = exp_rd;
      for (int unsigned i = 0; i < 4; i++)
        if (be[i]) nv[8*i +: 8] = wd[8*i +: 8];
      gold[wa]     = nv;
      m_dirty[idx] = 1'b1;
    end

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (hit) chk("hit_latency", 32'(n), 32'd1);
    else     chk("miss_resp", 32'(resp_valid), 32'd1);
    if (!we) chk("rdata", resp_rdata, exp_rd);
    chk("hit_count", hit_count, 32'(m_hits));
    chk("miss_count", miss_count, 32'(m_misses));
    cmp_traffic(hit ? "hit_mem" : "miss_mem");
    @(negedge clk);
    chk("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  task automatic do_flush(input bit twice, output int unsigned n_wr);
    int unsigned n;
    bit bad_ready;
    exp_q.delete();
    log_q.delete();
    for (int unsigned i = 0; i < 64; i++) begin
      if (m_valid[i] && m_dirty[i])
        for (int unsigned b = 0; b < 4; b++)
          exp_q.push_back('{we: 1'b1, addr: line_addr(m_tag[i], i, b), data: gold_rd(line_addr(m_tag[i], i, b))});
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    n_wr = exp_q.size();
    bad_ready = 1'b0;
    @(negedge clk);
    flush_req = 1'b1;
    for (int unsigned k = 0; k < (twice ? 2 : 1); k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (req_ready) bad_ready = 1'b1;
      end while (!flush_done && n < 3000);
      chk("flush_done", 32'(flush_done), 32'd1);
    end
    flush_req = 1'b0;
    chk("flush_ready_held", 32'(bad_ready), 32'd0);
    cmp_traffic("flush_mem");
    @(negedge clk);
    chk("flush_done_pulse", 32'(flush_done), 32'd0);
    chk("ready_after_flush", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int unsigned nw, n, mc;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; flush_req = 1'b0;
    m_hits = 0; m_misses = 0;
    for (int unsigned i = 0; i < 64; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; end

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Directed sequence
    do_access(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    do_access(1'b0, 32'h0000_0104, 32'h0, 4'h0);
    do_access(1'b1, 32'h0000_0108, 32'hAABB_CCDD, 4'b0101);
    do_access(1'b0, 32'h0000_0108, 32'h0, 4'h0);
    chk("merged_word", resp_rdata, (init_word(32'h108) & 32'hFF00_FF00) | 32'h00BB_00DD);
    do_access(1'b0, 32'h0000_1108, 32'h0, 4'h0);
    do_access(1'b1, 32'h0000_1108, 32'h1122_3344, 4'b1111);
    do_access(1'b1, 32'h0000_0204, 32'h5566_7788, 4'b0011);
    do_flush(1'b0, nw);
    chk("flush_beats", 32'(nw), 32'd8);
    mc = miss_count;
    do_access(1'b0, 32'h0000_0204, 32'h0, 4'h0);
    chk("miss_after_flush", miss_count, mc + 1);
    do_flush(1'b1, nw);

    // Reset in the middle of a stalled refill
    mem_stall = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_3000;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    chk("rst_test_mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mid_misses", miss_count, 32'd0);
    for (int unsigned i = 0; i < 64; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    m_hits = 0; m_misses = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_stall = 1'b0;
    @(negedge clk);
    do_access(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    chk("rst_rerun_miss", miss_count, 32'd1);

    // Randomized traffic over a small conflicting address window
    for (int unsigned it = 0; it < 300; it++) begin
      if (($urandom % 100) < 3) begin
        do_flush(1'b0, nw);
      end else begin
        do_access(1'($urandom % 2),
                  32'((($urandom % 4) << 10) | (($urandom % 4) << 4) | (($urandom % 4) << 2)),
                  $urandom, 4'($urandom % 16));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/cache_wb_ctrl.md
Name: cache_wb_ctrl

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache with an integrated miss-handling FSM. Supersedes the single-word cache, whose control lived outside it.
- Sits between the MIPS memory stage and main memory:
  - CPU side: valid/ready request port with a registered response.
  - Memory side: single-word request/ack port, used for line write-back and refill bursts.
- Adds multi-word lines, byte-enable writes, a whole-cache flush and hit/miss counters.

Parameters:
- LINES, 64, number of cache lines; power of 2, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, at least 1.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU access request
- req_ready  out  1  cache can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address; bits [1:0] are ignored
- req_wdata  in  32  store data
- req_be  in  4  store byte enables; bit i covers byte [8i+7:8i]
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  load data, valid while resp_valid=1
- mem_req  out  1  memory word request
- mem_we  out  1  1 = write to memory, 0 = read from memory
- mem_addr  out  ADDR_W  word-aligned memory address
- mem_wdata  out  32  write-back data
- mem_ack  in  1  memory completed the current word
- mem_rdata  in  32  refill data, valid when mem_ack=1
- flush_req  in  1  write back all dirty lines and invalidate the cache
- flush_done  out  1  one-cycle pulse: flush complete
- hit_count  out  32  saturating count of hits
- miss_count  out  32  saturating count of misses

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE), IDX = log2(LINES).
  - word offset = addr[2+OFF-1:2]; index = addr[2+OFF+IDX-1:2+OFF]; tag = the remaining upper bits.
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE; all valid and dirty bits clear.
  - All outputs 0, except req_ready=1 once in IDLE after rst_n is released.
  - Counters clear.
  - Data and tag arrays are not reset.
  - Reset during a burst aborts it immediately; mem_req drops in the same instant.
- FSM states: IDLE, WB, REFILL, RESPOND, FLUSH.
- IDLE:
  - req_ready = !flush_req.
  - flush_req has priority over req_valid.
  - Hit = valid[idx] and tag match.
  - Load hit: resp_rdata is the addressed word, resp_valid=1 the next cycle (latency 1).
  - Store hit: enabled bytes written, dirty set, resp_valid=1 the next cycle.
  - Miss: latch the request and increment miss_count. Go to WB if valid and dirty, otherwise go to REFILL.
  - Each hit increments hit_count. Both counters saturate at 0xFFFFFFFF.
- WB:
  - Address sequence: mem_addr = {old tag, idx, beat, 2'b00}, with beat running 0..WORDS_PER_LINE-1.
  - mem_req=1, mem_we=1, mem_wdata = line word[beat].
  - mem_req, mem_addr and mem_wdata stay stable until mem_ack. On mem_ack the beat advances.
  - After the last ack, clear dirty and go to REFILL.
  - No idle cycle is required between beats.
- REFILL:
  - Same beat sequence using the new tag; mem_req=1, mem_we=0.
  - On mem_ack, mem_rdata is written to word[beat].
  - After the last ack, write the tag, set valid, clear dirty, go to RESPOND.
- RESPOND:
  - Perform the latched access on the filled line. A store merges bytes and sets dirty.
  - resp_valid=1 with load data this cycle, then go to IDLE.
  - Miss latency = 1 + beats×(memory wait) + 1.
- FLUSH:
  - Scan lines 0..LINES-1.
  - A valid dirty line is written back as in WB.
  - Every line is invalidated.
  - After the last line: flush_done=1 for one cycle, go to IDLE.
  - Requests are held off (req_ready=0) throughout.
- Handshake rules:
  - req_ready=0 in every state except IDLE.
  - Request fields are sampled only on req_valid && req_ready.
  - mem_ack while mem_req=0 is ignored.
- Misses in the same index evict whatever line is resident (direct-mapped).
- A flush_req held high after flush_done starts a new flush.

Test Plan:
- Reset, then load 0x0000_0100 -> miss: 4 refill reads at 0x100, 0x104, 0x108, 0x10C, then resp_rdata = the memory word at 0x100; miss_count=1.
- Repeat the load of 0x104 -> resp_valid exactly 1 cycle after acceptance, no mem_req, hit_count=1.
- Store 0xAABBCCDD be=4'b0101 to 0x108, then load 0x108 -> bytes 0 and 2 updated, bytes 1 and 3 unchanged.
- Load 0x1108 (same index, different tag) -> 4 write-backs at 0x100..0x10C carrying the merged word, then 4 refill reads at 0x1100..0x110C.
- Dirty lines at two indices, assert flush_req -> exactly 8 write beats, one flush_done pulse; the next access to either address misses.
- Drop rst_n mid-refill with mem_ack stalled -> mem_req=0 immediately; after reset the same address misses again.
